// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ibex data-bus arbiter.
// Host identifiers are stored in the response-ordering FIFO.
package ibex_pkg;

  typedef enum logic {
    DbusHostLsu = 1'b0,
    DbusHostRf  = 1'b1
  } dbus_host_e;

  localparam int unsigned DbusMaxOutstandingDefault = 2;

endpackage

// File: rtl/ibex_dbus_id_fifo.sv
// In-order FIFO of host IDs for granted transactions awaiting a response.
// Pointers wrap at Depth, so non-power-of-two depths are supported.
module ibex_dbus_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = DbusMaxOutstandingDefault,
  parameter bit          ResetAll = 1'b0,
  localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  dbus_host_e      push_id_i,
  input  logic            pop_i,
  output dbus_host_e      head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  dbus_host_e      mem_d [Depth];
  dbus_host_e      mem_q [Depth];
  logic [PtrW-1:0] wptr_d, wptr_q;
  logic [PtrW-1:0] rptr_d, rptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == {CntW{1'b0}});
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_id_i;
      wptr_d        = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= {PtrW{1'b0}};
      rptr_q  <= {PtrW{1'b0}};
      count_q <= {CntW{1'b0}};
      if (ResetAll) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= DbusHostLsu;
        end
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ibex_dbus_arbiter.sv
// Two-host arbiter sharing the Ibex data bus between the LSU and the
// register-file cache spill/fill engine, with in-order response routing.
module ibex_dbus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = DbusMaxOutstandingDefault,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,

  input  logic        rf_req_i,
  input  logic        rf_we_i,
  input  logic [3:0]  rf_be_i,
  input  logic [31:0] rf_addr_i,
  input  logic [31:0] rf_wdata_i,
  output logic        rf_gnt_o,
  output logic        rf_rvalid_o,
  output logic [31:0] rf_rdata_o,
  output logic        rf_err_o,

  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            lock_d, lock_q;
  dbus_host_e      lock_host_d, lock_host_q;
  dbus_host_e      last_d, last_q;
  dbus_host_e      owner;
  dbus_host_e      head;
  logic            owner_req;
  logic            dev_req, dev_gnt, resp_ok;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  ibex_dbus_id_fifo #(
    .Depth    (MaxOutstanding),
    .ResetAll (ResetAll)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (dev_gnt),
    .push_id_i (owner),
    .pop_i     (resp_ok),
    .head_o    (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Owner selection: a pending ungranted request pins the owner, ties go round-robin.
  always_comb begin
    owner = DbusHostLsu;
    if (lock_q) begin
      owner = lock_host_q;
    end else if (lsu_req_i && rf_req_i) begin
      owner = (last_q == DbusHostLsu) ? DbusHostRf : DbusHostLsu;
    end else if (rf_req_i) begin
      owner = DbusHostRf;
    end else begin
      owner = DbusHostLsu;
    end
  end

  always_comb begin
    owner_req    = lsu_req_i;
    data_we_o    = lsu_we_i;
    data_be_o    = lsu_be_i;
    data_addr_o  = lsu_addr_i;
    data_wdata_o = lsu_wdata_i;
    if (owner == DbusHostRf) begin
      owner_req    = rf_req_i;
      data_we_o    = rf_we_i;
      data_be_o    = rf_be_i;
      data_addr_o  = rf_addr_i;
      data_wdata_o = rf_wdata_i;
    end else begin
      owner_req    = lsu_req_i;
      data_we_o    = lsu_we_i;
      data_be_o    = lsu_be_i;
      data_addr_o  = lsu_addr_i;
      data_wdata_o = lsu_wdata_i;
    end
  end

  assign dev_req = ~rst_i & owner_req & ~fifo_full;
  assign dev_gnt = dev_req & data_gnt_i;
  assign resp_ok = ~rst_i & data_rvalid_i & ~fifo_empty;

  assign data_req_o     = dev_req;
  assign lsu_gnt_o      = dev_gnt & (owner == DbusHostLsu);
  assign rf_gnt_o       = dev_gnt & (owner == DbusHostRf);
  assign lsu_rvalid_o   = resp_ok & (head == DbusHostLsu);
  assign rf_rvalid_o    = resp_ok & (head == DbusHostRf);
  assign lsu_err_o      = lsu_rvalid_o & data_err_i;
  assign rf_err_o       = rf_rvalid_o & data_err_i;
  assign lsu_rdata_o    = data_rdata_i;
  assign rf_rdata_o     = data_rdata_i;
  assign busy_o         = ~rst_i & (fifo_count != {CntW{1'b0}});
  assign protocol_err_o = ~rst_i & data_rvalid_i & fifo_empty;

  always_comb begin
    lock_d      = lock_q;
    lock_host_d = lock_host_q;
    last_d      = last_q;
    if (data_gnt_i) begin
      lock_d = 1'b0;
    end else if (dev_req) begin
      lock_d      = 1'b1;
      lock_host_d = owner;
    end else begin
      lock_d = lock_q;
    end
    if (dev_gnt) begin
      last_d = owner;
    end else begin
      last_d = last_q;
    end
  end

  // Last winner resets to RF so the LSU wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      last_q <= DbusHostRf;
      if (ResetAll) begin
        lock_host_q <= DbusHostLsu;
      end
    end else begin
      lock_q      <= lock_d;
      last_q      <= last_d;
      lock_host_q <= lock_host_d;
    end
  end

endmodule

// File: tb/tb_ibex_dbus_arbiter.sv
// Randomized plus directed bench for ibex_dbus_arbiter, checked every cycle
// against a queue-based transaction model.
module tb_ibex_dbus_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, rf_req_i, rf_we_i;
  logic [3:0]  lsu_be_i, rf_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, rf_addr_i, rf_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic        rf_gnt_o, rf_rvalid_o, rf_err_o;
  logic [31:0] lsu_rdata_o, rf_rdata_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        busy_o, protocol_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: host IDs in grant order (1 = RF), round-robin and lock memory.
  bit m_q[$];
  bit m_last_rf = 1'b1;
  bit m_locked  = 1'b0;
  bit m_lock_rf = 1'b0;

  always #5 clk = ~clk;

  ibex_dbus_arbiter #(.MaxOutstanding(MAX), .ResetAll(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .rf_req_i(rf_req_i), .rf_we_i(rf_we_i), .rf_be_i(rf_be_i),
    .rf_addr_i(rf_addr_i), .rf_wdata_i(rf_wdata_i),
    .rf_gnt_o(rf_gnt_o), .rf_rvalid_o(rf_rvalid_o),
    .rf_rdata_o(rf_rdata_o), .rf_err_o(rf_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input bit rst, input bit lreq, input bit rreq, input bit gnt,
                      input bit rv, input bit err, input logic [31:0] rdata);
    bit owner_rf, oreq, ereq, g, resp, head_rf;
    @(negedge clk);
    rst_i         = rst;
    lsu_req_i     = lreq;
    rf_req_i      = rreq;
    lsu_we_i      = 1'($urandom());
    rf_we_i       = 1'($urandom());
    lsu_be_i      = 4'($urandom());
    rf_be_i       = 4'($urandom());
    lsu_addr_i    = $urandom();
    rf_addr_i     = $urandom();
    lsu_wdata_i   = $urandom();
    rf_wdata_i    = $urandom();
    data_gnt_i    = gnt;
    data_rvalid_i = rv;
    data_err_i    = err;
    data_rdata_i  = rdata;
    #1;
    if (rst) begin
      check_eq("rst_req",    data_req_o, 0);
      check_eq("rst_gnt",    {lsu_gnt_o, rf_gnt_o}, 0);
      check_eq("rst_rvalid", {lsu_rvalid_o, rf_rvalid_o}, 0);
      check_eq("rst_err",    {lsu_err_o, rf_err_o}, 0);
      check_eq("rst_busy",   busy_o, 0);
      check_eq("rst_perr",   protocol_err_o, 0);
      m_q.delete();
      m_last_rf = 1'b1;
      m_locked  = 1'b0;
    end else begin
      if (m_locked)          owner_rf = m_lock_rf;
      else if (lreq && rreq) owner_rf = !m_last_rf;
      else                   owner_rf = rreq;
      oreq    = owner_rf ? rreq : lreq;
      ereq    = oreq && (m_q.size() < MAX);
      g       = ereq && gnt;
      resp    = rv && (m_q.size() > 0);
      head_rf = resp ? m_q[0] : 1'b0;
      check_eq("data_req",   data_req_o, ereq);
      check_eq("data_addr",  data_addr_o,  owner_rf ? rf_addr_i  : lsu_addr_i);
      check_eq("data_wdata", data_wdata_o, owner_rf ? rf_wdata_i : lsu_wdata_i);
      check_eq("data_we",    data_we_o,    owner_rf ? rf_we_i    : lsu_we_i);
      check_eq("data_be",    data_be_o,    owner_rf ? rf_be_i    : lsu_be_i);
      check_eq("lsu_gnt",    lsu_gnt_o, g && !owner_rf);
      check_eq("rf_gnt",     rf_gnt_o,  g && owner_rf);
      check_eq("lsu_rvalid", lsu_rvalid_o, resp && !head_rf);
      check_eq("rf_rvalid",  rf_rvalid_o,  resp && head_rf);
      check_eq("lsu_err",    lsu_err_o, resp && !head_rf && err);
      check_eq("rf_err",     rf_err_o,  resp && head_rf && err);
      check_eq("lsu_rdata",  lsu_rdata_o, rdata);
      check_eq("rf_rdata",   rf_rdata_o,  rdata);
      check_eq("busy",       busy_o, m_q.size() != 0);
      check_eq("perr",       protocol_err_o, rv && (m_q.size() == 0));
      if (resp) void'(m_q.pop_front());
      if (g) begin
        m_q.push_back(owner_rf);
        m_last_rf = owner_rf;
      end
      if (gnt) m_locked = 1'b0;
      else if (ereq) begin
        m_locked  = 1'b1;
        m_lock_rf = owner_rf;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    lsu_req_i = 1'b0; rf_req_i = 1'b0; lsu_we_i = 1'b0; rf_we_i = 1'b0;
    lsu_be_i = 4'h0; rf_be_i = 4'h0;
    lsu_addr_i = 32'h0; rf_addr_i = 32'h0; lsu_wdata_i = 32'h0; rf_wdata_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;

    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 1, 0, 32'h0);

    // Tie-break: alternate LSU, RF, ... starting with LSU.
    step(0, 1, 1, 1, 0, 0, 32'h1);
    check_eq("tie_first_lsu", lsu_gnt_o, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1, 0, $urandom());

    // Lock: RF alone ungranted, LSU joins; RF keeps the bus until granted.
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 0, 32'h0);
    check_eq("lock_addr_rf", data_addr_o, rf_addr_i);
    step(0, 1, 1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 0, 0, 32'h0);
    check_eq("lock_rf_gnt", rf_gnt_o, 1);
    step(0, 1, 0, 1, 1, 0, 32'h0);
    check_eq("lock_lsu_next", lsu_gnt_o, 1);

    // Ordering, then full-FIFO stall and simultaneous grant/response.
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 1, 0, 0, 32'h0);
    step(0, 1, 0, 1, 0, 0, 32'h0);
    check_eq("full_no_req", data_req_o, 0);
    step(0, 1, 0, 1, 1, 0, 32'hA5A5A5A5);
    check_eq("order_lsu_first", lsu_rvalid_o, 1);
    step(0, 1, 0, 1, 1, 1, 32'h5A5A5A5A);
    check_eq("order_rf_second", rf_rvalid_o, 1);
    check_eq("rf_err_routed", rf_err_o, 1);
    step(0, 0, 1, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    check_eq("perr_empty", protocol_err_o, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    check_eq("perr_one_cycle", protocol_err_o, 0);

    // Reset with one outstanding, then a late response.
    step(0, 1, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    check_eq("rst_mid_busy", busy_o, 0);
    step(0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    check_eq("late_rvalid", {lsu_rvalid_o, rf_rvalid_o}, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199, 0) == 0, 1'($urandom()), 1'($urandom()),
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, 1'($urandom()), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_dbus_arbiter.md
IBEX_DBUS_ARBITER -- requirements
Module: ibex_dbus_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, the maximum number of device-side transactions granted but not yet responded to (legal range 1..4).
REQ-002 SHALL have parameter ResetAll, default 1'b0; when 1, datapath registers are also reset.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have host 0 (core LSU) ports lsu_req_i, lsu_we_i, lsu_be_i[3:0], lsu_addr_i[31:0], lsu_wdata_i[31:0] as inputs, and lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o[31:0], lsu_err_o as outputs.
REQ-006 SHALL have host 1 (register-file cache spill/fill engine) ports rf_req_i, rf_we_i, rf_be_i[3:0], rf_addr_i[31:0], rf_wdata_i[31:0] as inputs, and rf_gnt_o, rf_rvalid_o, rf_rdata_o[31:0], rf_err_o as outputs.
REQ-007 SHALL have device ports data_req_o, data_we_o, data_be_o[3:0], data_addr_o[31:0], data_wdata_o[31:0] as outputs, and data_gnt_i, data_rvalid_i, data_rdata_i[31:0], data_err_i as inputs.
REQ-008 SHALL have outputs busy_o (1), high while any transaction is outstanding, and protocol_err_o (1), a one-cycle pulse.

Function
REQ-009 SHALL select one owner per cycle:
- if the lock is set, the owner is the locked host;
- otherwise a single requester wins;
- if both hosts request, the host that did not win the last grant wins (round-robin).
REQ-010 SHALL drive data_we/be/addr/wdata_o from the owner's inputs combinationally, with zero-cycle latency.
REQ-011 SHALL assert data_req_o = owner_req AND (outstanding < MaxOutstanding).
REQ-012 SHALL set the lock when data_req_o=1 and data_gnt_i=0, and clear it on data_gnt_i=1, so that the owner cannot change while a request is ungranted.
REQ-013 SHALL assert the owner's gnt_o = data_req_o AND data_gnt_i, and SHALL hold the other host's gnt_o at 0.
REQ-014 SHALL, on each device grant, push the owner ID into an in-order ID FIFO of depth MaxOutstanding and update the last-winner register.
REQ-015 SHALL, on data_rvalid_i with a non-empty FIFO:
- pop the FIFO head;
- assert rvalid_o for the head host only;
- drive data_rdata_i to both rdata_o buses;
- gate err_o to the head host.
REQ-016 SHALL, on data_rvalid_i with an empty FIFO, drop the response, assert no host rvalid_o, and pulse protocol_err_o.
REQ-017 SHALL, on a grant and a response in the same cycle, pop the pre-push head, push the new ID, and leave the count unchanged.
REQ-018 SHALL, when the FIFO is full, keep data_req_o low, assert no gnt_o, and not set the lock; the host request is held pending.
REQ-019 SHALL keep FIFO pointers in log2(MaxOutstanding) bits with wrap-around, and the count in clog2(MaxOutstanding+1) bits.
REQ-020 SHALL assert busy_o = (count != 0).

Reset
REQ-021 SHALL, on rst_i=1 at a clock edge, set:
- count = 0, FIFO pointers = 0, lock = 0;
- last winner = host 1, so that host 0 wins the first tie.
REQ-022 SHALL hold these outputs at 0 during and after reset until a new request arrives: data_req_o, gnt_o, rvalid_o, err_o, busy_o, protocol_err_o.
REQ-023 SHALL, on reset mid-operation, discard outstanding IDs; device responses arriving after reset are handled per REQ-016.

Structure
REQ-024 SHALL take typedef dbus_host_e {DbusHostLsu=0, DbusHostRf=1} and constant DbusMaxOutstandingDefault=2 from ibex_pkg.
REQ-025 SHALL implement the ID FIFO as sub-module ibex_dbus_id_fifo (push/pop/head/count/full/empty).
REQ-026 SHALL be instantiated between the core data port and the register-file cache in ibex_top.

Verification
REQ-027 SHALL cover tie-break: both hosts request with gnt=1 every cycle -> grants alternate LSU, RF, LSU, RF starting with LSU after reset.
REQ-028 SHALL cover the lock: RF requests alone, gnt=0 for 3 cycles, LSU raises req in cycle 2 -> data_addr_o stays rf_addr_i until gnt, then LSU is granted next.
REQ-029 SHALL cover ordering: LSU then RF granted back-to-back, rdata 0xA5A5A5A5 then 0x5A5A5A5A -> lsu_rvalid_o with 0xA5A5A5A5 first, rf_rvalid_o with 0x5A5A5A5A second.
REQ-030 SHALL cover full: 2 grants outstanding, LSU requests -> data_req_o=0 until an rvalid, then data_req_o=1 on the next cycle; simultaneous grant and rvalid keep the count at 2.
REQ-031 SHALL cover errors: data_err_i=1 on an RF response -> rf_err_o=1, lsu_err_o=0; an rvalid with an empty FIFO -> protocol_err_o pulses exactly 1 cycle.
REQ-032 SHALL cover reset mid-operation: rst_i asserted with 1 outstanding -> busy_o=0 the next cycle, and a late rvalid produces no host rvalid.
